// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the burst-master state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;
    localparam logic [2:0] HSIZE_QWORD = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } mst_state_e;

    // NONSEQ and SEQ both have bit 1 set; these are the transfers a slave accepts.
    function automatic logic trans_active(input logic [1:0] t);
        return t[1];
    endfunction

endpackage

// File: rtl/ahb_lite_burst_master_if.sv
// AHB-Lite address/data bus bundle between the burst master and the interconnect.
interface ahb_lite_burst_master_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic          hwrite;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;

    modport master (
        output haddr, htrans, hsize, hburst, hwrite, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hsize, hburst, hwrite, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_addr_gen.sv
// Beat address stepping and remaining-beat counter for the burst master.
module ahb_addr_gen #(
    parameter int AW   = 32,
    parameter int LENW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [LENW-1:0] len,
    input  logic [AW-1:0]   addr,
    input  logic [2:0]      size,
    output logic [AW-1:0]   next_addr,
    output logic            cross_1k,
    output logic            last
);
    logic [LENW-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst)
            remaining <= '0;
        else if (load)
            remaining <= len;
        else if (step && remaining != '0)
            remaining <= remaining - LENW'(1);
    end

    assign next_addr = addr + (AW'(1) << size);
    assign cross_1k  = next_addr[AW-1:10] != addr[AW-1:10];
    assign last      = remaining == '0;

endmodule

// File: rtl/ahb_lite_burst_master.sv
// AHB-Lite master turning single commands into SINGLE/INCR bursts with
// wait-state, BUSY-insertion, 1 KB-boundary and error-response handling.
module ahb_lite_burst_master
    import ahb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int LENW = 4
) (
    input  logic            hclk,
    input  logic            hreset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LENW-1:0] cmd_len,
    input  logic [2:0]      cmd_size,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [DW-1:0]   wr_data,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            rd_last,
    output logic            done,
    output logic            err,
    ahb_lite_burst_master_if.master ahb
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));

    mst_state_e      state;
    logic            cmd_write_q;
    logic [AW-1:0]   cmd_addr_q;
    logic [LENW-1:0] cmd_len_q;
    logic [2:0]      cmd_size_q;

    logic [AW-1:0]   haddr_q;
    logic [2:0]      hsize_q;
    logic [2:0]      hburst_q;
    logic            hwrite_q;
    logic [DW-1:0]   hwdata_q;
    logic [1:0]      htrans_c;

    logic            force_nonseq;
    logic            dphase;
    logic            dphase_last;
    logic            beat_go;
    logic            cmd_bad;
    logic [AW-1:0]   align_mask;
    logic [AW-1:0]   next_addr;
    logic            cross_1k;
    logic            last_beat;

    ahb_addr_gen #(.AW(AW), .LENW(LENW)) u_addr_gen (
        .clk       (hclk),
        .rst       (hreset),
        .load      (state == ST_CHECK),
        .step      (beat_go),
        .len       (cmd_len_q),
        .addr      (haddr_q),
        .size      (hsize_q),
        .next_addr (next_addr),
        .cross_1k  (cross_1k),
        .last      (last_beat)
    );

    assign align_mask = (AW'(1) << cmd_size_q) - AW'(1);
    assign cmd_bad    = (cmd_size_q > MAX_SIZE) || ((cmd_addr_q & align_mask) != '0);

    // A beat is only offered when its write word is already present; otherwise
    // the slot becomes IDLE before the first beat (or after a 1 KB restart) and BUSY mid-burst.
    always_comb begin
        htrans_c = HTRANS_IDLE;
        if (state == ST_ADDR) begin
            if (!hwrite_q || wr_valid)
                htrans_c = force_nonseq ? HTRANS_NONSEQ : HTRANS_SEQ;
            else
                htrans_c = force_nonseq ? HTRANS_IDLE : HTRANS_BUSY;
        end
    end

    assign beat_go   = ahb.hready && trans_active(htrans_c);
    assign wr_ready  = ahb.hready && hwrite_q && trans_active(htrans_c);
    assign cmd_ready = (state == ST_IDLE) && !hreset;

    assign ahb.haddr  = haddr_q;
    assign ahb.htrans = htrans_c;
    assign ahb.hsize  = hsize_q;
    assign ahb.hburst = hburst_q;
    assign ahb.hwrite = hwrite_q;
    assign ahb.hwdata = hwdata_q;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state        <= ST_IDLE;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            cmd_size_q   <= '0;
            haddr_q      <= '0;
            hsize_q      <= '0;
            hburst_q     <= '0;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
            force_nonseq <= 1'b0;
            dphase       <= 1'b0;
            dphase_last  <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_last      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_write_q <= cmd_write;
                        cmd_addr_q  <= cmd_addr;
                        cmd_len_q   <= cmd_len;
                        cmd_size_q  <= cmd_size;
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cmd_bad) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        haddr_q      <= cmd_addr_q;
                        hsize_q      <= cmd_size_q;
                        hburst_q     <= (cmd_len_q == '0) ? HBURST_SINGLE : HBURST_INCR;
                        hwrite_q     <= cmd_write_q;
                        force_nonseq <= 1'b1;
                        dphase       <= 1'b0;
                        state        <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_DRAIN: begin
                    if (dphase && ahb.hresp) begin
                        dphase <= 1'b0;
                        state  <= ST_ERR1;
                    end else begin
                        // Data phase of the previous beat and address phase of the
                        // next one retire on the same hready edge.
                        if (dphase && ahb.hready) begin
                            if (!hwrite_q) begin
                                rd_valid <= 1'b1;
                                rd_data  <= ahb.hrdata;
                                rd_last  <= dphase_last;
                            end
                            if (dphase_last) begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                        if (beat_go) begin
                            haddr_q      <= next_addr;
                            force_nonseq <= cross_1k;
                            dphase_last  <= last_beat;
                            if (hwrite_q)
                                hwdata_q <= wr_data;
                            if (last_beat)
                                state <= ST_DRAIN;
                        end
                        if (ahb.hready)
                            dphase <= beat_go;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                ST_ERR2: begin
                    if (ahb.hready) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Directed bench for ahb_lite_burst_master: bench drives the AHB slave side cycle by cycle.
module tb_ahb_lite_burst_master;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int LENW = 4;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic            clk = 1'b0;
    logic            hreset;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [LENW-1:0] cmd_len;
    logic [2:0]      cmd_size;
    logic            wr_valid, wr_ready;
    logic [DW-1:0]   wr_data;
    logic            rd_valid, rd_last, done, err;
    logic [DW-1:0]   rd_data;

    int checks = 0;
    int errors = 0;

    ahb_lite_burst_master_if #(.DW(DW), .AW(AW)) bus ();

    ahb_lite_burst_master #(.DW(DW), .AW(AW), .LENW(LENW)) dut (
        .hclk      (clk),
        .hreset    (hreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .err       (err),
        .ahb       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [LENW-1:0] l,
                        input logic [2:0] s);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
    endtask

    initial begin
        hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_size = '0; wr_valid = 1'b0; wr_data = '0;
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_htrans", bus.htrans, T_IDLE);
        chk("rst_haddr", bus.haddr, 0);
        chk("rst_hwdata", bus.hwdata, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        tick(); hreset = 1'b0; #1;
        chk("rel_cmd_ready", cmd_ready, 1);

        // Single write, zero wait
        tick(); send(1, 32'h100, 0, 2); wr_valid = 1; wr_data = 32'hDEADBEEF; #1;
        chk("t1_accept_ready", cmd_ready, 1);
        tick(); cmd_valid = 0; #1;
        chk("t1_check_htrans", bus.htrans, T_IDLE);
        chk("t1_check_ready", cmd_ready, 0);
        tick(); #1;
        chk("t1_htrans", bus.htrans, T_NSEQ);
        chk("t1_haddr", bus.haddr, 32'h100);
        chk("t1_hburst", bus.hburst, 3'b000);
        chk("t1_hsize", bus.hsize, 2);
        chk("t1_hwrite", bus.hwrite, 1);
        chk("t1_wr_ready", wr_ready, 1);
        tick(); wr_valid = 0; #1;
        chk("t1_dp_htrans", bus.htrans, T_IDLE);
        chk("t1_hwdata", bus.hwdata, 32'hDEADBEEF);
        chk("t1_dp_done", done, 0);
        tick(); #1;
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_ready_again", cmd_ready, 1);
        tick(); #1;
        chk("t1_done_pulse", done, 0);

        // 4-beat read, two wait states on the second beat's data phase
        tick(); send(0, 32'h200, 3, 2); #1;
        tick(); cmd_valid = 0; #1;
        tick(); #1;
        chk("t2_b0_htrans", bus.htrans, T_NSEQ);
        chk("t2_b0_haddr", bus.haddr, 32'h200);
        chk("t2_hburst", bus.hburst, 3'b001);
        tick(); bus.hrdata = 32'hA0A0A0A0; #1;
        chk("t2_b1_htrans", bus.htrans, T_SEQ);
        chk("t2_b1_haddr", bus.haddr, 32'h204);
        tick(); bus.hready = 0; #1;
        chk("t2_rd0_valid", rd_valid, 1);
        chk("t2_rd0_data", rd_data, 32'hA0A0A0A0);
        chk("t2_rd0_last", rd_last, 0);
        chk("t2_b2_haddr", bus.haddr, 32'h208);
        chk("t2_b2_htrans", bus.htrans, T_SEQ);
        tick(); #1;
        chk("t2_wait_haddr", bus.haddr, 32'h208);
        chk("t2_wait_htrans", bus.htrans, T_SEQ);
        chk("t2_wait_rd_valid", rd_valid, 0);
        tick(); bus.hready = 1; bus.hrdata = 32'hA1A1A1A1; #1;
        chk("t2_wait2_haddr", bus.haddr, 32'h208);
        tick(); bus.hrdata = 32'hA2A2A2A2; #1;
        chk("t2_rd1_valid", rd_valid, 1);
        chk("t2_rd1_data", rd_data, 32'hA1A1A1A1);
        chk("t2_b3_haddr", bus.haddr, 32'h20C);
        chk("t2_b3_htrans", bus.htrans, T_SEQ);
        tick(); bus.hrdata = 32'hA3A3A3A3; #1;
        chk("t2_rd2_data", rd_data, 32'hA2A2A2A2);
        chk("t2_rd2_last", rd_last, 0);
        chk("t2_drain_htrans", bus.htrans, T_IDLE);
        tick(); #1;
        chk("t2_rd3_valid", rd_valid, 1);
        chk("t2_rd3_data", rd_data, 32'hA3A3A3A3);
        chk("t2_rd3_last", rd_last, 1);
        chk("t2_done", done, 1);
        chk("t2_err", err, 0);

        // Write starvation: three BUSY slots after the first beat
        tick(); send(1, 32'h300, 3, 2); wr_valid = 1; wr_data = 32'h11111111; #1;
        tick(); cmd_valid = 0; #1;
        tick(); #1;
        chk("t3_b0_htrans", bus.htrans, T_NSEQ);
        chk("t3_b0_haddr", bus.haddr, 32'h300);
        chk("t3_b0_wr_ready", wr_ready, 1);
        tick(); wr_valid = 0; #1;
        chk("t3_busy1_htrans", bus.htrans, T_BUSY);
        chk("t3_busy1_haddr", bus.haddr, 32'h304);
        chk("t3_hwdata0", bus.hwdata, 32'h11111111);
        chk("t3_busy1_wr_ready", wr_ready, 0);
        tick(); #1;
        chk("t3_busy2_htrans", bus.htrans, T_BUSY);
        tick(); #1;
        chk("t3_busy3_htrans", bus.htrans, T_BUSY);
        chk("t3_busy3_haddr", bus.haddr, 32'h304);
        tick(); wr_valid = 1; wr_data = 32'h22222222; #1;
        chk("t3_b1_htrans", bus.htrans, T_SEQ);
        chk("t3_b1_haddr", bus.haddr, 32'h304);
        chk("t3_b1_wr_ready", wr_ready, 1);
        tick(); wr_data = 32'h33333333; #1;
        chk("t3_b2_haddr", bus.haddr, 32'h308);
        chk("t3_hwdata1", bus.hwdata, 32'h22222222);
        tick(); wr_data = 32'h44444444; #1;
        chk("t3_b3_htrans", bus.htrans, T_SEQ);
        chk("t3_b3_haddr", bus.haddr, 32'h30C);
        chk("t3_hwdata2", bus.hwdata, 32'h33333333);
        tick(); wr_valid = 0; #1;
        chk("t3_drain_htrans", bus.htrans, T_IDLE);
        chk("t3_hwdata3", bus.hwdata, 32'h44444444);
        chk("t3_drain_done", done, 0);
        tick(); #1;
        chk("t3_done", done, 1);
        chk("t3_err", err, 0);

        // 1 KB boundary crossing restarts with NONSEQ
        tick(); send(0, 32'h3F8, 3, 2); #1;
        tick(); cmd_valid = 0; #1;
        tick(); #1;
        chk("t4_b0_htrans", bus.htrans, T_NSEQ);
        chk("t4_b0_haddr", bus.haddr, 32'h3F8);
        tick(); #1;
        chk("t4_b1_htrans", bus.htrans, T_SEQ);
        chk("t4_b1_haddr", bus.haddr, 32'h3FC);
        tick(); #1;
        chk("t4_b2_htrans", bus.htrans, T_NSEQ);
        chk("t4_b2_haddr", bus.haddr, 32'h400);
        tick(); #1;
        chk("t4_b3_htrans", bus.htrans, T_SEQ);
        chk("t4_b3_haddr", bus.haddr, 32'h404);
        tick(); #1;
        chk("t4_drain_htrans", bus.htrans, T_IDLE);
        tick(); #1;
        chk("t4_done", done, 1);
        chk("t4_rd_last", rd_last, 1);

        // Two-cycle ERROR on the second beat's data phase
        tick(); send(0, 32'h500, 3, 2); #1;
        tick(); cmd_valid = 0; #1;
        tick(); #1;
        chk("t5_b0_htrans", bus.htrans, T_NSEQ);
        tick(); bus.hrdata = 32'hB0B0B0B0; #1;
        chk("t5_b1_haddr", bus.haddr, 32'h504);
        tick(); bus.hready = 0; bus.hresp = 1; #1;
        chk("t5_rd0_data", rd_data, 32'hB0B0B0B0);
        chk("t5_err1_htrans", bus.htrans, T_SEQ);
        tick(); bus.hready = 1; bus.hresp = 1; #1;
        chk("t5_cancel_htrans", bus.htrans, T_IDLE);
        chk("t5_cancel_rd_valid", rd_valid, 0);
        tick(); bus.hresp = 0; #1;
        chk("t5_err2_htrans", bus.htrans, T_IDLE);
        chk("t5_err2_done", done, 0);
        tick(); #1;
        chk("t5_done", done, 1);
        chk("t5_err", err, 1);
        chk("t5_done_htrans", bus.htrans, T_IDLE);
        tick(); #1;
        chk("t5_ready_again", cmd_ready, 1);
        chk("t5_done_pulse", done, 0);

        // Reset in the middle of a burst
        tick(); send(0, 32'h600, 3, 2); #1;
        tick(); cmd_valid = 0; #1;
        tick(); #1;
        chk("t6_b0_htrans", bus.htrans, T_NSEQ);
        tick(); hreset = 1; #1;
        chk("t6_rst_cmd_ready", cmd_ready, 0);
        tick(); #1;
        chk("t6_htrans", bus.htrans, T_IDLE);
        chk("t6_haddr", bus.haddr, 0);
        chk("t6_hsize", bus.hsize, 0);
        chk("t6_hburst", bus.hburst, 0);
        chk("t6_hwdata", bus.hwdata, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_done", done, 0);
        tick(); hreset = 0; #1;
        chk("t6_rel_ready", cmd_ready, 1);
        tick(); #1;
        chk("t6_no_done", done, 0);

        // Oversized HSIZE for a 32-bit bus
        tick(); send(1, 32'h700, 0, 3); #1;
        tick(); cmd_valid = 0; #1;
        chk("t7_check_htrans", bus.htrans, T_IDLE);
        tick(); #1;
        chk("t7_done", done, 1);
        chk("t7_err", err, 1);
        chk("t7_htrans", bus.htrans, T_IDLE);
        chk("t7_haddr", bus.haddr, 0);
        tick(); #1;
        chk("t7_ready_again", cmd_ready, 1);

        // Misaligned start address
        tick(); send(0, 32'h702, 0, 2); #1;
        tick(); cmd_valid = 0; #1;
        tick(); #1;
        chk("t8_done", done, 1);
        chk("t8_err", err, 1);
        chk("t8_htrans", bus.htrans, T_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_burst_master.md
# ahb_lite_burst_master

Synthesizable, parametrised AHB-Lite master engine for testbench and on-chip use. It converts single-entry commands (address, beat count, size, direction) into AHB-Lite INCR bursts, with wait-state, BUSY-insertion, 1 KB-boundary and error-response handling. It sits between a local command/data-stream client and an AHB-Lite interconnect, and is the parametrised successor to the task-based AHB master VIP.

## Interface
Parameters:
- `DW`, 32: data bus width. Must be 8, 16, 32, 64 or 128.
- `AW`, 32: address width.
- `LENW`, 4: width of `cmd_len`. Maximum burst length is 2^LENW beats.

Ports (all single-clock-domain):
- `hclk` in 1: clock. One clock; everything is sampled on the rising edge.
- `hreset` in 1: reset. Synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in AW: start address. Must be aligned to `cmd_size`.
- `cmd_len` in LENW: beats minus 1.
- `cmd_size` in 3: AHB HSIZE encoding.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in DW: write-data stream.
- `rd_valid` out 1, `rd_data` out DW, `rd_last` out 1: read-data stream. No backpressure.
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: valid with `done`.
- `haddr` out AW, `htrans` out 2, `hsize` out 3, `hburst` out 3, `hwrite` out 1, `hwdata` out DW: AHB master outputs.
- `hrdata` in DW, `hready` in 1, `hresp` in 1: AHB slave responses.

## Operation
- **Reset values.** `cmd_ready`=0 while `hreset` is high, then 1. `htrans`=IDLE(00). `haddr`, `hsize`, `hburst`, `hwrite`, `hwdata`=0. `wr_ready`, `rd_valid`, `rd_last`, `done`, `err`=0.
- **States:**
  - IDLE: `cmd_ready`=1.
  - CHECK: one cycle.
  - ADDR: issuing beats.
  - DRAIN: last data phase.
  - ERR1/ERR2: two-cycle error response.
- **Transitions:**
  - IDLE→CHECK on `cmd_valid & cmd_ready`.
  - CHECK→IDLE with `done`=`err`=1 and no bus activity if `cmd_size` > log2(DW/8) or `cmd_addr` is misaligned.
  - Otherwise CHECK→ADDR.
- **Burst type.** `hburst`=SINGLE(000) if `cmd_len`=0, else INCR(001).
- **Beat encoding.** First beat is NONSEQ; later beats are SEQ, and the address increments by 2^`cmd_size`.
- **1 KB boundary.** If the next address crosses a 1 KB boundary, that beat is NONSEQ instead of SEQ.
- **Write beats.** A beat is presented only when `wr_valid`=1.
  - Write data not available on the first beat: `htrans` stays IDLE.
  - Write data not available mid-burst: drive BUSY(01) with the next beat's address.
  - `wr_valid` must hold once asserted, until `wr_ready`.
- **Write-data capture.** `wr_ready` = `hready` & `hwrite` & `htrans`∈{NONSEQ,SEQ}. `wr_data` is registered into `hwdata` on that edge.
- **Read beats.** On a read data phase completing with `hready`=1 and `hresp`=0: `rd_valid`=1 and `rd_data`=`hrdata`. `rd_last` is set on the final beat.
- **Error.** `hresp`=1 with `hready`=0 → ERR1.
  - `htrans` is driven IDLE that same next edge.
  - All remaining beats are cancelled.
  - ERR2 waits for `hready`=1, then `done`=`err`=1 → IDLE.
- **Normal completion.** `done`=1 and `err`=0 one cycle after the final data phase completes.

## Timing
- **Command to bus.**
  - Command accept edge → CHECK → first NONSEQ on the bus at the 2nd edge after acceptance.
  - Minimum command-to-`done` latency for a 1-beat zero-wait command: 4 cycles.
- **Address holding.** Address/control are held stable while `hready`=0.
- **Pipelining.** Back-to-back beats: one beat per cycle when `hready`=1, with address and data phases overlapped.
- **Read data.** `rd_valid` appears on the cycle after the completing data-phase edge, as a registered output.
- **Mid-operation reset.** `hreset` mid-burst forces all outputs to reset values at the next edge. No `done` is generated.
- **Back-to-back commands.** A new command is accepted only in IDLE, i.e. the cycle after `done`.

## Structure
- **Package `ahb_pkg`:**
  - HTRANS constants (IDLE/BUSY/NONSEQ/SEQ).
  - HBURST constants (SINGLE/INCR).
  - HSIZE constants.
  - Master state enum.
- **Sub-module `ahb_addr_gen`:** next-address increment by size and 1 KB-crossing flag. Purely combinational plus a beat-count register.

## Test plan
- **Single write, zero wait.** Write, addr 0x100, len 0, size 2, data 0xDEADBEEF → NONSEQ/SINGLE at 0x100, `hwdata`=0xDEADBEEF next cycle, `done`=1, `err`=0.
- **4-beat read with waits.** Read 0x200, len 3, `hready` low 2 cycles on beat 2 → haddr 0x200/204/208/20C held during the wait, 4 `rd_valid` pulses, `rd_last` on the 4th.
- **Write starvation.** Write len 3 with `wr_valid` low for 3 cycles after beat 1 → `htrans`=BUSY for 3 cycles at 0x...4, then SEQ resumes. No data lost.
- **1 KB boundary.** Read from 0x3F8, len 3, size 2 → NONSEQ 0x3F8, SEQ 0x3FC, NONSEQ 0x400, SEQ 0x404.
- **Error response.** `hresp` two-cycle ERROR on beat 2 of 4 → `htrans` IDLE next edge, no further beats, `done`=`err`=1.
- **Reset and bad size.** `hreset` mid-burst → all outputs zero/IDLE next edge. Separately, `cmd_size`=3 with DW=32 → `done`=`err`=1, no bus activity.
